at_accum_ctrl: RTL and testbench
================================

# at_accum_ctrl

Sequencer for the registered adder-tree accumulator in the PE array. For each job it clears the accumulator, gates `num_passes` input vectors into it under a valid/ready handshake, and waits one cycle for the registered sum to settle. It then captures the sum and presents it on a held valid/ready output port. It sits between the operand feeder (upstream) and the output/requantisation stage (downstream).

## Interface
- `PE_OUT_WIDTH`, 12: accumulator output width (4 + 8 headroom bits).
- `CNT_WIDTH`, 10: width of the pass count and pass counter.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `num_passes`  in  CNT_WIDTH  vectors to accumulate; latched on accepted `start`.
- `abort`  in  1  synchronous abort; returns to IDLE from any state.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  feeder has a vector on the accumulator inputs.
- `in_ready`  out  1  controller accepts a vector this cycle.
- `at_reset`  out  1  synchronous clear to the accumulator.
- `at_en`  out  1  accumulate enable to the accumulator.
- `at_o`  in  PE_OUT_WIDTH  accumulator register output.
- `out_valid`  out  1  `out_data` holds a finished sum.
- `out_ready`  in  1  downstream accepts `out_data`.
- `out_data`  out  PE_OUT_WIDTH  captured sum.
- `pass_cnt`  out  CNT_WIDTH  vectors accepted in the current job.

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, OUTPUT.
- IDLE: `start`=1 latches `num_passes` into `np_q`, clears `pass_cnt`, and moves to CLEAR. `start` is ignored in every other state.
- CLEAR: one cycle with `at_reset`=1. Next state is ACCUM if `np_q`≠0, else DRAIN.
- ACCUM: `in_ready`=1 and `at_en` = `in_valid & in_ready` (combinational).
  - Each accepted beat increments `pass_cnt`.
  - The beat accepted while `pass_cnt`==`np_q`−1 is the last; the next state is DRAIN.
  - `in_valid`=0 stalls with no state change.
- DRAIN: one cycle, no `at_en`. `at_o` now holds the final sum. On exit, `out_data` <= `at_o` and the next state is OUTPUT.
- OUTPUT: `out_valid`=1. `out_data` is stable until `out_valid & out_ready`, which moves the FSM to IDLE.
- Outputs are decoded from the state: `at_reset`=CLEAR, `in_ready`=ACCUM, `out_valid`=OUTPUT, `busy`=not IDLE.
- `abort`=1 (any state) moves the FSM to IDLE at the next edge.
  - `abort` has priority over `start` and over all handshakes.
  - `in_ready` and `at_en` are forced to 0 in the `abort` cycle.
  - `out_data` is preserved; `pass_cnt` clears.
- Arithmetic: `pass_cnt` is unsigned; `np_q` up to 2^CNT_WIDTH−1 must be supported without wrap. `out_data` is a raw copy of `at_o`, two's complement, no saturation.

## Timing
- `reset` low (asynchronous): state=IDLE, `np_q`=0, `pass_cnt`=0, `out_data`=0, `out_valid`=0, `busy`=0, `in_ready`=0, `at_en`=0, `at_reset`=0.
- The effect of `reset` rising is synchronous to the next `clk` edge.
- `start` sampled high at edge 0 gives: CLEAR in cycle 1, ACCUM from cycle 2.
- With no stalls and N≥1, the last beat is in cycle N+1, DRAIN is cycle N+2, and `out_valid` rises in cycle N+3.
- N=0: CLEAR in cycle 1, DRAIN in cycle 2, `out_valid` in cycle 3, `out_data`=0.
- From the last accepted beat to `out_valid` is 2 cycles regardless of stalls.
- A new `start` can be accepted one cycle after the output handshake, since the FSM passes through IDLE for one cycle.
- `out_ready` held high in OUTPUT gives `out_valid` high for exactly 1 cycle.
- Reset mid-job discards all job state immediately. The accumulator is not cleared by this block until the next job's CLEAR.

## Test plan
Bench models the accumulator as a register: clear on `at_reset`, `O += psum` on `at_en`.
- Reset, then `start` with `num_passes`=3, psums 5, −2, 7 back-to-back, `out_ready`=1 → `out_valid` in cycle 6 only, `out_data`=12'h00A, `at_en` high in cycles 2–4.
- `num_passes`=4 with `in_valid` toggled 1,0,0,1,1,0,1, psums 1 each → exactly 4 `at_en` pulses, `pass_cnt`=4, `out_data`=4, `out_valid` 2 cycles after the 4th beat.
- `num_passes`=0 → `at_reset` in cycle 1, `at_en` never high, `out_valid` in cycle 3, `out_data`=0.
- Job yielding −20 with `out_ready` held low for 5 cycles, `start` pulsed during OUTPUT → `out_data`=12'hFEC stable for all 6 valid cycles, `start` ignored, FSM in IDLE after the handshake.
- Two jobs: first sum 9, second sum 3 → second `out_data`=3 (CLEAR between jobs verified); `abort` asserted in ACCUM after 2 of 5 beats → FSM in IDLE next cycle, `out_valid` stays 0, previous `out_data` retained.
- `reset` asserted low asynchronously mid-ACCUM (between edges) → all outputs zero immediately, `busy`=0; after release, a new job with `num_passes`=1 and psum 6 → `out_data`=6.

Source files
------------

// File: rtl/at_accum_ctrl_if.sv
// rtl/at_accum_ctrl_if.sv - input-beat, accumulator and result-port signals of at_accum_ctrl
// master is the controller side; slave is the feeder/accumulator/downstream side.
interface at_accum_ctrl_if #(
  parameter int PE_OUT_WIDTH = 12
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    at_reset;
  logic                    at_en;
  logic [PE_OUT_WIDTH-1:0] at_o;
  logic                    out_valid;
  logic                    out_ready;
  logic [PE_OUT_WIDTH-1:0] out_data;

  modport master (
    input  in_valid, at_o, out_ready,
    output in_ready, at_reset, at_en, out_valid, out_data
  );

  modport slave (
    output in_valid, at_o, out_ready,
    input  in_ready, at_reset, at_en, out_valid, out_data
  );
endinterface

// File: rtl/at_accum_ctrl.sv
// rtl/at_accum_ctrl.sv - job sequencer for the registered adder-tree accumulator
// Clears the accumulator, gates num_passes beats into it, lets the sum settle, then holds it on the output port.
module at_accum_ctrl #(
  parameter int PE_OUT_WIDTH = 12,
  parameter int CNT_WIDTH    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_passes,
  input  logic                 abort,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pass_cnt,
  at_accum_ctrl_if.master      bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_OUTPUT
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    np_q, np_d;
  logic [CNT_WIDTH-1:0]    pass_cnt_q, pass_cnt_d;
  logic [PE_OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                    beat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      np_q       <= '0;
      pass_cnt_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      np_q       <= np_d;
      pass_cnt_q <= pass_cnt_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    np_d       = np_q;
    pass_cnt_d = pass_cnt_q;
    out_data_d = out_data_q;
    beat       = 1'b0;
    // Abort wins over start and every handshake; the last result stays visible.
    if (abort) begin
      state_d    = S_IDLE;
      pass_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            np_d       = num_passes;
            pass_cnt_d = '0;
            state_d    = S_CLEAR;
          end
        end
        S_CLEAR: begin
          state_d = (np_q != '0) ? S_ACCUM : S_DRAIN;
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            beat       = 1'b1;
            pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
            // np_q is nonzero here, so np_q-1 cannot wrap.
            if (pass_cnt_q == np_q - CNT_WIDTH'(1)) begin
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          out_data_d = bus.at_o;
          state_d    = S_OUTPUT;
        end
        S_OUTPUT: begin
          if (bus.out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_ACCUM) && !abort;
  assign bus.at_en     = beat;
  assign bus.at_reset  = (state_q == S_CLEAR);
  assign bus.out_valid = (state_q == S_OUTPUT);
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != S_IDLE);
  assign pass_cnt      = pass_cnt_q;

endmodule

// File: tb/tb_at_accum_ctrl.sv
// tb/tb_at_accum_ctrl.sv - directed self-checking bench for at_accum_ctrl
// The accumulator is modelled as a register: cleared by at_reset, O += psum on at_en.
module tb_at_accum_ctrl;
  localparam int W  = 12;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] num_passes;
  logic          busy;
  logic [CW-1:0] pass_cnt;
  logic [W-1:0]  psum;
  logic [W-1:0]  acc = '0;
  int            n_pass = 0;
  int            n_total = 0;
  int            en_cnt;
  bit            pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  at_accum_ctrl_if #(.PE_OUT_WIDTH(W)) bus ();

  at_accum_ctrl #(.PE_OUT_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_passes (num_passes),
    .abort      (abort),
    .busy       (busy),
    .pass_cnt   (pass_cnt),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.at_reset)   acc <= '0;
    else if (bus.at_en) acc <= acc + psum;
  end
  assign bus.at_o = acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; num_passes = '0; psum = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_at_en", bus.at_en, 0);
    chk("rst_at_reset", bus.at_reset, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    reset = 1'b1;
    tick();

    // Job 1: N=3, psums 5,-2,7 back-to-back
    start = 1'b1; num_passes = 10'd3; bus.out_ready = 1'b1;
    tick(); start = 1'b0; #1;
    chk("j1_c1_at_reset", bus.at_reset, 1);
    chk("j1_c1_busy", busy, 1);
    chk("j1_c1_in_ready", bus.in_ready, 0);
    tick(); bus.in_valid = 1'b1; psum = 12'd5; #1;
    chk("j1_c2_at_en", bus.at_en, 1);
    chk("j1_c2_in_ready", bus.in_ready, 1);
    tick(); psum = 12'hFFE; #1;
    chk("j1_c3_at_en", bus.at_en, 1);
    tick(); psum = 12'd7; #1;
    chk("j1_c4_at_en", bus.at_en, 1);
    chk("j1_c4_pass_cnt", pass_cnt, 2);
    tick(); bus.in_valid = 1'b0; #1;
    chk("j1_c5_at_en", bus.at_en, 0);
    chk("j1_c5_out_valid", bus.out_valid, 0);
    chk("j1_c5_pass_cnt", pass_cnt, 3);
    tick(); #1;
    chk("j1_c6_out_valid", bus.out_valid, 1);
    chk("j1_c6_out_data", bus.out_data, 12'h00A);
    tick(); #1;
    chk("j1_c7_out_valid", bus.out_valid, 0);
    chk("j1_c7_busy", busy, 0);

    // Job 2: N=4, in_valid pattern 1,0,0,1,1,0,1, psum 1
    start = 1'b1; num_passes = 10'd4; bus.out_ready = 1'b0; en_cnt = 0;
    tick(); start = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = pat[i]; psum = 12'd1; #1;
      if (bus.at_en) en_cnt++;
      tick();
    end
    bus.in_valid = 1'b0; #1;
    chk("j2_drain_out_valid", bus.out_valid, 0);
    chk("j2_drain_at_en", bus.at_en, 0);
    chk("j2_pass_cnt", pass_cnt, 4);
    chk("j2_en_pulses", en_cnt, 4);
    tick(); #1;
    chk("j2_out_valid", bus.out_valid, 1);
    chk("j2_out_data", bus.out_data, 4);
    bus.out_ready = 1'b1;
    tick(); #1;
    chk("j2_idle", busy, 0);

    // Job 3: N=0
    start = 1'b1; num_passes = 10'd0;
    tick(); start = 1'b0; #1;
    chk("j3_c1_at_reset", bus.at_reset, 1);
    tick(); bus.in_valid = 1'b1; #1;
    chk("j3_c2_at_en", bus.at_en, 0);
    chk("j3_c2_in_ready", bus.in_ready, 0);
    chk("j3_c2_out_valid", bus.out_valid, 0);
    chk("j3_c2_busy", busy, 1);
    tick(); bus.in_valid = 1'b0; #1;
    chk("j3_c3_out_valid", bus.out_valid, 1);
    chk("j3_c3_out_data", bus.out_data, 0);
    tick(); #1;
    chk("j3_idle", busy, 0);

    // Job 4: sum -20, out_ready low for 5 cycles, start pulsed in OUTPUT
    start = 1'b1; num_passes = 10'd2; bus.out_ready = 1'b0;
    tick(); start = 1'b0;
    tick(); bus.in_valid = 1'b1; psum = 12'hFF6;
    tick();
    tick(); bus.in_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      start = (k == 2); #1;
      chk("j4_hold_valid", bus.out_valid, 1);
      chk("j4_hold_data", bus.out_data, 12'hFEC);
      tick();
    end
    start = 1'b0; bus.out_ready = 1'b1; #1;
    chk("j4_last_valid", bus.out_valid, 1);
    chk("j4_last_data", bus.out_data, 12'hFEC);
    tick(); #1;
    chk("j4_idle", busy, 0);
    tick(); #1;
    chk("j4_start_ignored", busy, 0);

    // Job 5a: sum 9
    start = 1'b1; num_passes = 10'd1;
    tick(); start = 1'b0;
    tick(); bus.in_valid = 1'b1; psum = 12'd9;
    tick(); bus.in_valid = 1'b0;
    tick(); #1;
    chk("j5a_out_data", bus.out_data, 9);
    tick();
    // Job 5b: sum 3, accumulator must have been cleared
    start = 1'b1; num_passes = 10'd3;
    tick(); start = 1'b0;
    tick(); bus.in_valid = 1'b1; psum = 12'd1;
    tick();
    tick();
    tick(); bus.in_valid = 1'b0;
    tick(); #1;
    chk("j5b_out_valid", bus.out_valid, 1);
    chk("j5b_out_data", bus.out_data, 3);
    tick();

    // Abort after 2 of 5 beats
    start = 1'b1; num_passes = 10'd5;
    tick(); start = 1'b0;
    tick(); bus.in_valid = 1'b1; psum = 12'd1;
    tick();
    tick(); abort = 1'b1; #1;
    chk("ab_in_ready", bus.in_ready, 0);
    chk("ab_at_en", bus.at_en, 0);
    chk("ab_pass_cnt_pre", pass_cnt, 2);
    tick(); abort = 1'b0; #1;
    chk("ab_busy", busy, 0);
    chk("ab_pass_cnt", pass_cnt, 0);
    chk("ab_out_data_kept", bus.out_data, 3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ab_out_valid_low", bus.out_valid, 0);
    end
    bus.in_valid = 1'b0;

    // Asynchronous reset mid-ACCUM, then a fresh job
    start = 1'b1; num_passes = 10'd3;
    tick(); start = 1'b0;
    tick(); bus.in_valid = 1'b1; psum = 12'd1;
    tick(); #2;
    reset = 1'b0; #1;
    chk("ar_busy", busy, 0);
    chk("ar_in_ready", bus.in_ready, 0);
    chk("ar_at_en", bus.at_en, 0);
    chk("ar_at_reset", bus.at_reset, 0);
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_out_data", bus.out_data, 0);
    chk("ar_pass_cnt", pass_cnt, 0);
    #1; reset = 1'b1; bus.in_valid = 1'b0;
    tick();
    start = 1'b1; num_passes = 10'd1;
    tick(); start = 1'b0;
    tick(); bus.in_valid = 1'b1; psum = 12'd6;
    tick(); bus.in_valid = 1'b0;
    tick(); #1;
    chk("ar_job_out_valid", bus.out_valid, 1);
    chk("ar_job_out_data", bus.out_data, 6);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
